// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, instruction layout and widths for the 8-bit CPU
package cpu_pkg;
    localparam int DATA_W = 8;
    localparam int NUM_REGS = 8;
    localparam int INSTR_W = 9;
    localparam int REG_W = 3;
    localparam logic [2:0] OP_XOR = 3'b000;
    localparam logic [2:0] OP_BEQ = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_ANDI = 3'b011;
    localparam logic [2:0] OP_LS = 3'b100;
    typedef struct packed {
        logic [2:0] opcode;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs;
    } instr_t;
    function automatic logic writes_reg(input logic [2:0] op);
        return op == OP_XOR || op == OP_ADDI || op == OP_ANDI || op == OP_LS;
    endfunction
    function automatic logic uses_rs2(input logic [2:0] op);
        return op == OP_XOR || op == OP_BEQ;
    endfunction
endpackage

// File: rtl/reg_file.sv
// reg_file: register file with two combinational read ports and one synchronous write port
module reg_file
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_W-1:0]  ra1,
    input  logic [REG_W-1:0]  ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [REG_W-1:0]  wa,
    input  logic [DATA_W-1:0] wd
);
    logic [DATA_W-1:0] regs [NUM_REGS];
    assign rd1 = regs[ra1];
    assign rd2 = regs[ra2];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we) begin
            regs[wa] <= wd;
        end
    end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes instructions, resolves hazards and issues one registered ALU operation per cycle
module alu_issue_stage
    import cpu_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2:0]         out_instruction,
    output logic [DATA_W-1:0]  out_input1,
    output logic [DATA_W-1:0]  out_input2,
    output logic [REG_W-1:0]   out_rd,
    output logic               out_wb_en,
    input  logic               wb_valid,
    input  logic [REG_W-1:0]   wb_rd,
    input  logic [DATA_W-1:0]  wb_data
);
    instr_t ins;
    logic [DATA_W-1:0] r1, r2, a, b, op2;
    logic [NUM_REGS-1:0] busy, clr, set, busy_eff;
    logic use_rs2, wr, hazard, accept;
    assign ins = instr_t'(in_instr);
    reg_file u_rf (
        .clk(Clk), .rst(Reset), .ra1(ins.rd), .ra2(ins.rs), .rd1(r1), .rd2(r2),
        .we(wb_valid), .wa(wb_rd), .wd(wb_data)
    );
    always_comb begin
        use_rs2 = uses_rs2(ins.opcode);
        wr = writes_reg(ins.opcode);
        clr = wb_valid ? NUM_REGS'(1) << wb_rd : '0;
        busy_eff = busy & ~clr;
        // rs1 and the destination share [5:3], so one lookup covers both
        hazard = busy_eff[ins.rd] || (use_rs2 && busy_eff[ins.rs]);
        in_ready = (!out_valid || out_ready) && !hazard;
        accept = in_valid && in_ready;
        set = accept && wr ? NUM_REGS'(1) << ins.rd : '0;
        a = wb_valid && wb_rd == ins.rd ? wb_data : r1;
        b = wb_valid && wb_rd == ins.rs ? wb_data : r2;
        op2 = use_rs2 ? b :
              ins.opcode == OP_ADDI ? {{(DATA_W-3){ins.rs[2]}}, ins.rs} :
              ins.opcode == OP_ANDI || ins.opcode == OP_LS ? DATA_W'(ins.rs) : '0;
    end
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            busy <= '0;
            out_valid <= 1'b0;
            out_instruction <= '0;
            out_input1 <= '0;
            out_input2 <= '0;
            out_rd <= '0;
            out_wb_en <= 1'b0;
        end else begin
            busy <= (busy & ~clr) | set;
            if (accept) begin
                out_valid <= 1'b1;
                out_instruction <= ins.opcode;
                out_input1 <= a;
                out_input2 <= op2;
                out_rd <= ins.rd;
                out_wb_en <= wr;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: scoreboard-based self-checking bench for alu_issue_stage
module tb_alu_issue_stage;
    logic Clk = 1'b0, Reset = 1'b1;
    logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_wb_en;
    logic [8:0] in_instr = '0;
    logic [2:0] out_instruction, out_rd;
    logic [7:0] out_input1, out_input2;
    logic wb_valid = 1'b0;
    logic [2:0] wb_rd = '0;
    logic [7:0] wb_data = '0;
    logic [7:0] mreg [8];
    logic [7:0] mbusy;
    logic [22:0] sb [$];
    logic [22:0] e, held;
    int vectors = 0, misc = 0;

    alu_issue_stage dut (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_instruction(out_instruction),
        .out_input1(out_input1), .out_input2(out_input2), .out_rd(out_rd), .out_wb_en(out_wb_en),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    always #5 Clk = ~Clk;

    function automatic logic [22:0] outs();
        return {out_instruction, out_input1, out_input2, out_rd, out_wb_en};
    endfunction

    function automatic logic [22:0] model(input logic [8:0] i);
        logic [2:0] op, rd, rs;
        logic [7:0] a, b, in2;
        logic wbe;
        op = i[8:6]; rd = i[5:3]; rs = i[2:0];
        a = (wb_valid && wb_rd == rd) ? wb_data : mreg[rd];
        b = (wb_valid && wb_rd == rs) ? wb_data : mreg[rs];
        case (op)
            3'b000, 3'b001: in2 = b;
            3'b010: in2 = {{5{rs[2]}}, rs};
            3'b011, 3'b100: in2 = {5'b0, rs};
            default: in2 = 8'h00;
        endcase
        wbe = (op == 3'b000 || op == 3'b010 || op == 3'b011 || op == 3'b100);
        return {op, a, in2, rd, wbe};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
        mbusy = '0;
        sb.delete();
    endtask

    task automatic wb(input logic [2:0] r, input logic [7:0] d);
        wb_valid = 1'b1; wb_rd = r; wb_data = d;
        tick();
        wb_valid = 1'b0;
        mreg[r] = d;
        mbusy[r] = 1'b0;
    endtask

    task automatic send(input logic [8:0] i);
        int n;
        in_valid = 1'b1; in_instr = i; out_ready = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            vectors++; misc++;
            $display("FAIL send_timeout: in_ready=%b want 1 for instr %b", in_ready, i);
        end else begin
            sb.push_back(model(i));
            if (model(i) & 23'h1) mbusy[i[5:3]] = 1'b1;
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        vectors++;
        if (out_valid !== 1'b0 || outs() !== '0) begin
            misc++; $display("FAIL reset_outs: got %b/%h want 0/0", out_valid, outs());
        end
        #4 Reset = 1'b0;
        clear_model();
        tick();
    endtask

    task automatic test_xor();
        wb(3'd1, 8'h0F);
        wb(3'd2, 8'h3C);
        send(9'b000_001_010);
        e = sb.size() ? sb.pop_front() : 'x; vectors++;
        if (out_valid !== 1'b1 || outs() !== e) begin
            misc++; $display("FAIL xor_out: got %b/%h want 1/%h", out_valid, outs(), e);
        end
        wb(3'd1, 8'h0F);
        vectors++;
        if (out_valid !== 1'b0) begin
            misc++; $display("FAIL drain: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_imm();
        logic [8:0] ops [3] = '{9'b010_100_111, 9'b011_100_111, 9'b100_100_101};
        for (int k = 0; k < 3; k++) begin
            send(ops[k]);
            e = sb.size() ? sb.pop_front() : 'x; vectors++;
            if (out_valid !== 1'b1 || outs() !== e) begin
                misc++; $display("FAIL imm_%0d: got %b/%h want 1/%h", k, out_valid, outs(), e);
            end
            wb(3'd4, 8'h21 + 8'(k * 8'h21));
        end
    endtask

    task automatic test_raw();
        send(9'b010_001_001);
        e = sb.size() ? sb.pop_front() : 'x; vectors++;
        if (out_valid !== 1'b1 || outs() !== e) begin
            misc++; $display("FAIL raw_addi: got %b/%h want 1/%h", out_valid, outs(), e);
        end
        in_valid = 1'b1; in_instr = 9'b000_001_010;
        for (int k = 0; k < 2; k++) begin
            #1; vectors++;
            if (in_ready !== 1'b0) begin
                misc++; $display("FAIL raw_stall_%0d: in_ready=%b want 0", k, in_ready);
            end
            tick();
        end
        wb_valid = 1'b1; wb_rd = 3'd1; wb_data = 8'h10;
        #1; vectors++;
        if (in_ready !== 1'b1) begin
            misc++; $display("FAIL raw_release: in_ready=%b want 1", in_ready);
        end
        sb.push_back(model(in_instr));
        tick();
        wb_valid = 1'b0; in_valid = 1'b0;
        mreg[1] = 8'h10; mbusy[1] = 1'b1;
        e = sb.size() ? sb.pop_front() : 'x; vectors++;
        if (out_valid !== 1'b1 || outs() !== e) begin
            misc++; $display("FAIL raw_bypass: got %b/%h want 1/%h", out_valid, outs(), e);
        end
        in_valid = 1'b1; in_instr = 9'b000_001_010;
        #1; vectors++;
        if (in_ready !== 1'b0) begin
            misc++; $display("FAIL set_wins: in_ready=%b want 0", in_ready);
        end
        in_valid = 1'b0;
        tick();
        wb(3'd1, 8'h10);
    endtask

    task automatic test_backpressure();
        send(9'b000_001_010);
        e = sb.size() ? sb.pop_front() : 'x; vectors++;
        if (out_valid !== 1'b1 || outs() !== e) begin
            misc++; $display("FAIL bp_first: got %b/%h want 1/%h", out_valid, outs(), e);
        end
        held = outs();
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 9'b011_101_010;
        for (int k = 0; k < 3; k++) begin
            #1; vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || outs() !== held) begin
                misc++; $display("FAIL bp_hold_%0d: rdy=%b v=%b out=%h want 0/1/%h", k, in_ready, out_valid, outs(), held);
            end
            tick();
        end
        out_ready = 1'b1;
        #1; vectors++;
        if (in_ready !== 1'b1) begin
            misc++; $display("FAIL bp_resume: in_ready=%b want 1", in_ready);
        end
        sb.push_back(model(in_instr)); mbusy[5] = 1'b1;
        tick();
        in_valid = 1'b0;
        e = sb.size() ? sb.pop_front() : 'x; vectors++;
        if (out_valid !== 1'b1 || outs() !== e) begin
            misc++; $display("FAIL bp_next: got %b/%h want 1/%h", out_valid, outs(), e);
        end
        wb(3'd1, 8'h10);
        wb(3'd5, 8'h55);
    endtask

    task automatic test_back_to_back();
        logic [8:0] ops [2] = '{9'b011_010_001, 9'b011_011_010};
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_instr = ops[k];
            #1; vectors++;
            if (in_ready !== 1'b1) begin
                misc++; $display("FAIL b2b_ready_%0d: in_ready=%b want 1", k, in_ready);
            end
            sb.push_back(model(ops[k]));
            tick();
            e = sb.size() ? sb.pop_front() : 'x; vectors++;
            if (out_valid !== 1'b1 || outs() !== e) begin
                misc++; $display("FAIL b2b_out_%0d: got %b/%h want 1/%h", k, out_valid, outs(), e);
            end
        end
        in_valid = 1'b0;
        wb(3'd2, 8'h3C);
        wb(3'd3, 8'h00);
    endtask

    task automatic test_passthru();
        wb(3'd7, 8'h77);
        send(9'b110_111_011);
        e = sb.size() ? sb.pop_front() : 'x; vectors++;
        if (out_valid !== 1'b1 || outs() !== e) begin
            misc++; $display("FAIL op110: got %b/%h want 1/%h", out_valid, outs(), e);
        end
        in_valid = 1'b1; in_instr = 9'b010_111_001;
        #1; vectors++;
        if (in_ready !== 1'b1) begin
            misc++; $display("FAIL op110_nobusy: in_ready=%b want 1", in_ready);
        end
        sb.push_back(model(in_instr));
        tick();
        in_valid = 1'b0;
        e = sb.size() ? sb.pop_front() : 'x; vectors++;
        if (out_valid !== 1'b1 || outs() !== e) begin
            misc++; $display("FAIL op110_next: got %b/%h want 1/%h", out_valid, outs(), e);
        end
        wb(3'd7, 8'h77);
    endtask

    task automatic test_reset_midstream();
        send(9'b010_011_001);
        out_ready = 1'b0;
        e = sb.size() ? sb.pop_front() : 'x; vectors++;
        if (out_valid !== 1'b1 || outs() !== e) begin
            misc++; $display("FAIL mid_pre: got %b/%h want 1/%h", out_valid, outs(), e);
        end
        Reset = 1'b1;
        #1; vectors++;
        if (out_valid !== 1'b0 || outs() !== '0) begin
            misc++; $display("FAIL mid_reset: got %b/%h want 0/0", out_valid, outs());
        end
        #1 Reset = 1'b0;
        clear_model();
        in_valid = 1'b1; in_instr = 9'b000_011_011; out_ready = 1'b1;
        #1; vectors++;
        if (in_ready !== 1'b1) begin
            misc++; $display("FAIL mid_nostall: in_ready=%b want 1", in_ready);
        end
        sb.push_back(model(in_instr));
        tick();
        in_valid = 1'b0;
        e = sb.size() ? sb.pop_front() : 'x; vectors++;
        if (out_valid !== 1'b1 || outs() !== e) begin
            misc++; $display("FAIL mid_zero: got %b/%h want 1/%h", out_valid, outs(), e);
        end
        wb(3'd3, 8'h00);
        send(9'b000_001_010);
        e = sb.size() ? sb.pop_front() : 'x; vectors++;
        if (out_valid !== 1'b1 || outs() !== e) begin
            misc++; $display("FAIL mid_regs: got %b/%h want 1/%h", out_valid, outs(), e);
        end
    endtask

    initial begin
        test_reset();
        test_xor();
        test_imm();
        test_raw();
        test_backpressure();
        test_back_to_back();
        test_passthru();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue stage directly upstream of the combinational ALU in the 8-bit custom CPU.
- Accepts 9-bit instructions over a valid/ready handshake and decodes them.
- Reads operands from an internal 8x8 register file, tracks pending writes with a per-register scoreboard, and presents one registered ALU operation per cycle.
- Takes ALU results back through a writeback port.

Parameters:
- NUM_REGS, 8, register file depth (register index width = 3).
- DATA_W, 8, datapath width.
- INSTR_W, 9, instruction width.

Ports:
- Clk  input  1  clock, all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  stage can accept this cycle.
- in_instr  input  9  [8:6] opcode, [5:3] rd/rs1, [2:0] rs2 or imm3.
- out_valid  output  1  ALU operation valid.
- out_ready  input  1  downstream consumed the operation.
- out_instruction  output  3  ALU instruction code.
- out_input1  output  8  ALU operand 1.
- out_input2  output  8  ALU operand 2.
- out_rd  output  3  destination register for writeback.
- out_wb_en  output  1  operation writes a register.
- wb_valid  input  1  writeback strobe.
- wb_rd  input  3  writeback register.
- wb_data  input  8  writeback value (ALU result).

Behaviour:
- Reset (async, while Reset=1):
  - all 8 registers = 0x00 and all busy bits = 0.
  - out_valid = 0; out_instruction / out_input1 / out_input2 / out_rd = 0; out_wb_en = 0.
  - An in-flight output is discarded. Pending writebacks are forgotten; wb_valid arriving after release still writes the register file.
- Opcodes:
  - 000 xor: in1 = R[rs1], in2 = R[rs2], wb.
  - 001 beq: in1 = R[rs1], in2 = R[rs2], no wb.
  - 010 addi: in2 = sign-extended imm3, wb.
  - 011 andi: in2 = zero-extended imm3, wb.
  - 100 ls: in2 = zero-extended imm3 (shift code), wb.
  - 101-111: passed through with in1 = R[rs1], in2 = 0x00, no wb. The ALU returns 0xFF and nothing is written.
- Destination is always [5:3].
- Sources:
  - rs1 = [5:3] for all opcodes.
  - rs2 = [2:0] only for xor and beq.
- Hazard: stall if any used source, or the destination of a wb instruction, has its busy bit set. A matching same-cycle writeback does not count (see bypass).
- Bypass: if wb_valid and wb_rd equals a source being read that cycle, the operand is wb_data.
- in_ready = (!out_valid || out_ready) && !hazard. It is combinational from the current in_instr and is not required to be independent of in_valid.
- Accept = in_valid && in_ready. The output registers load on the next edge, out_valid = 1 (latency 1 cycle). Back-to-back accepts are allowed at 1 per cycle.
- Hold: while out_valid && !out_ready, all out_* stay stable. No new accept is possible.
- Drain: out_ready with no accept clears out_valid on the next edge.
- Scoreboard:
  - Accept of a wb instruction sets busy[rd].
  - wb_valid clears busy[wb_rd] and writes R[wb_rd] = wb_data.
  - Same register set and cleared in one cycle: set wins.
- wb_valid for a non-busy register still writes the register file (used for initialisation).
- Arithmetic: the stage performs none except extension. All widths are exactly 8 bits.

Decomposition:
- Shared package cpu_pkg:
  - opcode localparams (OP_XOR=3'b000, OP_BEQ=3'b001, OP_ADDI=3'b010, OP_ANDI=3'b011, OP_LS=3'b100), which the ALU also uses.
  - packed struct typedef for instruction fields (opcode, rd, rs).
  - DATA_W.
- One sub-module: reg_file.
  - Two combinational read ports, one synchronous write port, asynchronous reset to zero.
  - Bypass and scoreboard live in alu_issue_stage.

Test Plan:
- Reset mid-stream with out_valid=1 and busy[3]=1: out_valid=0, busy cleared, R[0..7]=0x00. The next instruction is accepted without stall.
- Preload R1=0x0F, R2=0x3C via wb; issue xor 1,2 (9'b000_001_010) with out_ready=1: one cycle later out_valid=1, out_instruction=000, in1=0x0F, in2=0x3C, out_rd=1, out_wb_en=1.
- Issue addi 4,imm 3'b111: in2=0xFF. Issue andi 4,imm 3'b111: in2=0x07. Issue ls 4,3'b101: in2=0x05.
- RAW stall: accept addi 1,1 (busy[1]=1); next xor 1,2 sees in_ready=0 until wb_valid, wb_rd=1, wb_data=0x10. In that same cycle in_ready=1 and in1=0x10 via bypass.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1: out_* unchanged, in_ready=0. The next op is accepted on the cycle out_ready rises.
- Opcode 3'b110: out_instruction=110, in2=0x00, out_wb_en=0, no busy bit set.
